// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: start/busy/done magnitude comparator scanning two bits per cycle from the MSB pair down.
// Defining CMP_EARLY_EXIT_EN ends the scan at the first unequal chunk; otherwise all W/2 chunks are always walked.
module seq_mag_comparator #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sgn,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);
    localparam int N  = W / 2;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DN = 2'd2;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic [1:0]    state;
    logic [W-1:0]  ra, rb;
    logic [IW-1:0] idx;
    logic          pg, pl;
    logic [1:0]    ca, cb;
    logic          cg, cl, ng, nl, last;
    always_comb begin
        ca   = ra[{idx, 1'b0} +: 2];
        cb   = rb[{idx, 1'b0} +: 2];
        cg   = ca > cb;
        cl   = ca < cb;
        ng   = pg | (!pl & cg);
        nl   = pl | (!pg & cl);
        last = (idx == '0) || (EARLY && (cg || cl));
    end
    assign busy = state == RUN;
    assign done = state == DN;
    // pg/pl hold the first difference seen so later chunks cannot override it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            idx   <= '0;
            pg    <= 1'b0;
            pl    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else if (start && state != RUN) begin
            state <= RUN;
            ra    <= a ^ {sgn, {(W-1){1'b0}}};
            rb    <= b ^ {sgn, {(W-1){1'b0}}};
            idx   <= IW'(N - 1);
            pg    <= 1'b0;
            pl    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else if (state == RUN) begin
            if (last) begin
                state <= DN;
                gt    <= ng;
                lt    <= nl;
                eq    <= !ng && !nl;
            end else begin
                idx <= idx - 1'b1;
                pg  <= ng;
                pl  <= nl;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: directed checks of seq_mag_comparator with W=8 in either latency build.
module tb_seq_mag_comparator;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sgn = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic busy, done, gt, eq, lt;
    int passed = 0, fails = 0, total = 0;
    int lat, nd, first;

    seq_mag_comparator #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sgn(sgn),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic eg, input logic ee, input logic el);
        chk({tag, " res"}, {busy, done, gt, eq, lt}, {2'b01, eg, ee, el});
    endtask

    task automatic go(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic sv);
        a = av; b = bv; sgn = sv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; sgn = ~sv;
        chk({tag, " accept"}, {busy, done, gt, eq, lt}, 5'b10000);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        chk({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic hold(input string tag, input logic eg, input logic ee, input logic el);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " idle"}, {busy, done, gt, eq, lt}, {2'b00, eg, ee, el});
    endtask

    initial begin
        #3;
        chk("reset", {busy, done, gt, eq, lt}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        go("u80_7f", 8'h80, 8'h7F, 1'b0);
        wait_done("u80_7f", EE ? 1 : 4);
        chk_res("u80_7f", 1, 0, 0);
        hold("u80_7f", 1, 0, 0);

        go("s80_7f", 8'h80, 8'h7F, 1'b1);
        wait_done("s80_7f", EE ? 1 : 4);
        chk_res("s80_7f", 0, 0, 1);
        hold("s80_7f", 0, 0, 1);

        go("eq5a_u", 8'h5A, 8'h5A, 1'b0);
        wait_done("eq5a_u", 4);
        chk_res("eq5a_u", 0, 1, 0);
        go("eq5a_s", 8'h5A, 8'h5A, 1'b1);
        wait_done("eq5a_s", 4);
        chk_res("eq5a_s", 0, 1, 0);
        hold("eq5a_s", 0, 1, 0);

        go("busy", 8'h01, 8'h03, 1'b0);
        a = 8'hFF; b = 8'h00; sgn = 1'b0; start = 1'b1;
        nd = 0; first = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                nd++;
                if (first == 0) first = i;
            end
        end
        chk("busy ndone", nd, 1);
        chk("busy latency", first, 4);
        chk("busy res", {gt, eq, lt}, 3'b001);

        go("b2b1", 8'h10, 8'h20, 1'b0);
        wait_done("b2b1", EE ? 2 : 4);
        chk_res("b2b1", 0, 0, 1);
        go("b2b2", 8'h34, 8'h34, 1'b0);
        wait_done("b2b2", 4);
        chk_res("b2b2", 0, 1, 0);
        hold("b2b2", 0, 1, 0);

        go("rst", 8'hC3, 8'hC1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst async", {busy, done, gt, eq, lt}, 5'b00000);
        @(negedge clk);
        chk("rst held", {busy, done, gt, eq, lt}, 5'b00000);
        rst_n = 1'b1;
        @(negedge clk);
        go("post", 8'h02, 8'h01, 1'b0);
        wait_done("post", 4);
        chk_res("post", 1, 0, 0);
        hold("post", 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
